score_engine: RTL and testbench

//  Multi-lane successor to the single-channel scorer: counts note hits/misses on LANES lanes,

---
 rtl/score_pkg.sv | 25 ++
 rtl/bcd_iter.sv | 102 ++++++++++
 rtl/score_engine.sv | 189 ++++++++++++++++++
 tb/tb_score_engine.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/score_pkg.sv
// Shared types and defaults for the score engine: converter state encoding,
// lane popcount helper and gameplay tuning constants.
package score_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } bcd_state_e;

  localparam int DEF_BASE_PTS    = 50;
  localparam int DEF_STREAK_STEP = 10;
  localparam int DEF_MAX_MULT    = 4;

  // Number of set bits; lane vectors are zero-extended to 32 bits by the caller.
  function automatic logic [5:0] popcount(input logic [31:0] v);
    logic [5:0] n;
    n = '0;
    for (int i = 0; i < 32; i++) begin
      n = n + {5'b0, v[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/bcd_iter.sv
// Iterative binary-to-BCD converter (shift-add-3 double dabble), one bit per
// cycle. A start seen in IDLE or DONE latches the input and begins a new pass;
// done is high for the single cycle in which bcd holds the finished result.
//
// state | meaning
// IDLE  | waiting for start
// SHIFT | BIN_W shift-add-3 iterations in progress
// DONE  | bcd valid this cycle; a start here restarts immediately
module bcd_iter
  import score_pkg::*;
#(
  parameter int BIN_W  = 21,
  parameter int DIGITS = 7
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  abort,
  input  logic [BIN_W-1:0]      bin,
  output logic                  busy,
  output logic                  done,
  output logic [DIGITS*4-1:0]   bcd
);

  localparam int CNT_W = $clog2(BIN_W + 1);

  bcd_state_e                state_q, state_d;
  logic [DIGITS*4-1:0]       bcd_q, bcd_d, adj;
  logic [BIN_W-1:0]          bin_q, bin_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;

  // Converter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      bcd_q   <= '0;
      bin_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      bcd_q   <= bcd_d;
      bin_q   <= bin_d;
      cnt_q   <= cnt_d;
    end
  end

  // Add 3 to every digit that is 5 or more before the next left shift.
  always_comb begin
    adj = bcd_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) begin
        adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end
    end
  end

  // Next-state and datapath control; abort wins over everything.
  always_comb begin
    state_d = state_q;
    bcd_d   = bcd_q;
    bin_d   = bin_q;
    cnt_d   = cnt_q;
    if (abort) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            state_d = SHIFT;
            bcd_d   = '0;
            bin_d   = bin;
            cnt_d   = CNT_W'(BIN_W - 1);
          end
        end
        SHIFT: begin
          bcd_d = {adj[DIGITS*4-2:0], bin_q[BIN_W-1]};
          bin_d = {bin_q[BIN_W-2:0], 1'b0};
          cnt_d = cnt_q - 1'b1;
          if (cnt_q == '0) begin
            state_d = DONE;
          end
        end
        DONE: begin
          if (start) begin
            state_d = SHIFT;
            bcd_d   = '0;
            bin_d   = bin;
            cnt_d   = CNT_W'(BIN_W - 1);
          end else begin
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign busy = (state_q != IDLE);
  assign done = (state_q == DONE);
  assign bcd  = bcd_q;

endmodule

// File: rtl/score_engine.sv
// Multi-lane hit/miss scorer: streak, combo multiplier, saturating score and
// an iteratively converted BCD copy of the score for the hex displays.
// Optional feature macro: STAR_POWER_EN (adds star_req/star_active and a
// timed x2 multiplier; mult widens to 4 bits so the doubled value 8 fits).
module score_engine
  import score_pkg::*;
#(
  parameter int LANES       = 5,
  parameter int SCORE_W     = 21,
  parameter int DIGITS      = 7,
  parameter int STREAK_W    = 10,
  parameter int BASE_PTS    = DEF_BASE_PTS,
  parameter int STREAK_STEP = DEF_STREAK_STEP,
  parameter int MAX_MULT    = DEF_MAX_MULT,
`ifdef STAR_POWER_EN
  parameter int unsigned STAR_CYCLES = 500_000_000,
  localparam int MULT_W = 4
`else
  localparam int MULT_W = 3
`endif
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  pause,
  input  logic                  clear,
  input  logic [LANES-1:0]      note_hit,
  input  logic [LANES-1:0]      note_miss,
  output logic [SCORE_W-1:0]    score,
  output logic [STREAK_W-1:0]   streak,
  output logic [MULT_W-1:0]     mult,
  output logic [DIGITS*4-1:0]   score_bcd,
  output logic                  bcd_valid
`ifdef STAR_POWER_EN
  ,
  input  logic                  star_req,
  output logic                  star_active
`endif
);

  logic [SCORE_W-1:0]   score_q, score_d;
  logic [STREAK_W-1:0]  streak_q, streak_d;
  logic [2:0]           mult_q, mult_d;
  logic                 chg_q, chg_d;
  logic                 pending_q, pending_d;
  logic                 valid_q, valid_d;
  logic [DIGITS*4-1:0]  bcd_q, bcd_d;

  logic [LANES-1:0]     hit_v;
  logic [5:0]           hits;
  logic                 miss_any;
  logic                 star_on;
  logic [3:0]           mult_pts;
  logic [15:0]          pts;
  logic [SCORE_W:0]     score_sum;
  logic [STREAK_W:0]    streak_sum;
  logic [STREAK_W-1:0]  steps;

  logic                 cv_start, cv_busy, cv_done;
  logic [DIGITS*4-1:0]  cv_bcd;

`ifdef STAR_POWER_EN
  localparam int SC_W = $clog2(STAR_CYCLES + 1);
  logic [SC_W-1:0] star_cnt_q, star_cnt_d;

  // Star-power down-counter register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) star_cnt_q <= '0;
    else       star_cnt_q <= star_cnt_d;
  end

  // Load on an accepted request, count down while active; pause freezes it.
  always_comb begin
    star_cnt_d = star_cnt_q;
    if (clear) begin
      star_cnt_d = '0;
    end else if (!pause) begin
      if (star_on) begin
        star_cnt_d = star_cnt_q - 1'b1;
      end else if (star_req && (streak_q >= STREAK_W'(3 * STREAK_STEP))) begin
        star_cnt_d = SC_W'(STAR_CYCLES);
      end
    end
  end

  assign star_on     = (star_cnt_q != '0);
  assign star_active = star_on;
`else
  assign star_on = 1'b0;
`endif

  // Gameplay state registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      score_q   <= '0;
      streak_q  <= '0;
      mult_q    <= 3'd1;
      chg_q     <= 1'b0;
      pending_q <= 1'b0;
      valid_q   <= 1'b1;
      bcd_q     <= '0;
    end else begin
      score_q   <= score_d;
      streak_q  <= streak_d;
      mult_q    <= mult_d;
      chg_q     <= chg_d;
      pending_q <= pending_d;
      valid_q   <= valid_d;
      bcd_q     <= bcd_d;
    end
  end

  // Hit/miss scoring: a lane with both pulses counts as a miss, and any miss
  // forfeits the cycle's points. Points use the multiplier held before update.
  always_comb begin
    hit_v      = note_hit & ~note_miss;
    hits       = popcount(32'(hit_v));
    miss_any   = |note_miss;
    mult_pts   = {1'b0, mult_q} << star_on;
    pts        = 16'(hits) * 16'(BASE_PTS) * 16'(mult_pts);
    score_sum  = {1'b0, score_q} + (SCORE_W+1)'(pts);
    streak_sum = {1'b0, streak_q} + (STREAK_W+1)'(hits);
    steps      = '0;
    score_d    = score_q;
    streak_d   = streak_q;
    mult_d     = mult_q;
    if (clear) begin
      score_d  = '0;
      streak_d = '0;
      mult_d   = 3'd1;
    end else if (!pause) begin
      if (miss_any) begin
        streak_d = '0;
        mult_d   = 3'd1;
      end else begin
        score_d  = score_sum[SCORE_W] ? '1 : score_sum[SCORE_W-1:0];
        streak_d = streak_sum[STREAK_W] ? '1 : streak_sum[STREAK_W-1:0];
        steps    = streak_d / STREAK_W'(STREAK_STEP);
        mult_d   = (steps >= STREAK_W'(MAX_MULT - 1)) ? 3'(MAX_MULT) : 3'(steps) + 3'd1;
      end
    end
    // A clear forces the display to zero directly, so it must not trigger a conversion.
    chg_d = !clear && (score_d != score_q);
  end

  // Conversion sequencing: start from IDLE on a score change, restart from DONE
  // if the score moved meanwhile; bcd_valid drops in the very cycle score changes.
  always_comb begin
    cv_start  = !clear && ((!cv_busy && chg_q) || (cv_done && (chg_q || pending_q)));
    pending_d = pending_q;
    valid_d   = valid_q;
    bcd_d     = bcd_q;
    if (clear) begin
      pending_d = 1'b0;
      valid_d   = 1'b1;
      bcd_d     = '0;
    end else if (cv_start) begin
      pending_d = 1'b0;
      valid_d   = 1'b0;
      if (cv_done) bcd_d = cv_bcd;
    end else begin
      if (cv_busy && chg_q) pending_d = 1'b1;
      if (cv_done) begin
        valid_d = 1'b1;
        bcd_d   = cv_bcd;
      end
    end
  end

  bcd_iter #(
    .BIN_W  (SCORE_W),
    .DIGITS (DIGITS)
  ) u_bcd (
    .clk   (clk),
    .reset (reset),
    .start (cv_start),
    .abort (clear),
    .bin   (score_q),
    .busy  (cv_busy),
    .done  (cv_done),
    .bcd   (cv_bcd)
  );

  assign score     = score_q;
  assign streak    = streak_q;
  assign mult      = MULT_W'(mult_pts);
  assign score_bcd = bcd_q;
  assign bcd_valid = valid_q & ~cv_start;

endmodule

// File: tb/tb_score_engine.sv
// Directed, table-driven bench for score_engine with hand-computed expectations.
module tb_score_engine;

`ifdef STAR_POWER_EN
  localparam int MULT_W = 4;
`else
  localparam int MULT_W = 3;
`endif

  logic              clk = 1'b0;
  logic              reset, pause, clear;
  logic [4:0]        note_hit, note_miss;
  logic [20:0]       score;
  logic [9:0]        streak;
  logic [MULT_W-1:0] mult;
  logic [27:0]       score_bcd;
  logic              bcd_valid;
`ifdef STAR_POWER_EN
  logic              star_req, star_active;
`endif

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

`ifdef STAR_POWER_EN
  score_engine #(.STAR_CYCLES(20)) dut (
`else
  score_engine dut (
`endif
    .clk       (clk),
    .reset     (reset),
    .pause     (pause),
    .clear     (clear),
    .note_hit  (note_hit),
    .note_miss (note_miss),
    .score     (score),
    .streak    (streak),
    .mult      (mult),
    .score_bcd (score_bcd),
    .bcd_valid (bcd_valid)
`ifdef STAR_POWER_EN
    ,
    .star_req    (star_req),
    .star_active (star_active)
`endif
  );

  typedef struct {
    logic       p;
    logic       c;
    logic [4:0] hit;
    logic [4:0] miss;
    int         exp_score;
    int         exp_streak;
    int         exp_mult;
  } vec_t;

  vec_t tbl[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic apply(input logic p, input logic c, input logic [4:0] h, input logic [4:0] m);
    pause = p; clear = c; note_hit = h; note_miss = m;
    @(posedge clk); #1;
    pause = 1'b0; clear = 1'b0; note_hit = '0; note_miss = '0;
  endtask

  task automatic run_rows(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      apply(tbl[i].p, tbl[i].c, tbl[i].hit, tbl[i].miss);
      check($sformatf("row%0d_score", i),  64'(score),  64'(tbl[i].exp_score));
      check($sformatf("row%0d_streak", i), 64'(streak), 64'(tbl[i].exp_streak));
      check($sformatf("row%0d_mult", i),   64'(mult),   64'(tbl[i].exp_mult));
    end
  endtask

  // Wait for bcd_valid; any valid cycle must show the expected BCD.
  task automatic wait_bcd(input string name, input logic [27:0] exp_bcd, input int max_cyc,
                          output int cycles);
    bit seen;
    seen = 0;
    cycles = 0;
    for (int k = 0; k < max_cyc && !seen; k++) begin
      @(posedge clk); #1;
      cycles++;
      if (bcd_valid) seen = 1;
    end
    check({name, "_valid_timeout"}, 64'(seen), 64'd1);
    check({name, "_bcd"}, 64'(score_bcd), 64'(exp_bcd));
  endtask

  function automatic vec_t mk(input logic p, input logic c, input logic [4:0] h,
                              input logic [4:0] m, input int s, input int st, input int mu);
    vec_t v;
    v.p = p; v.c = c; v.hit = h; v.miss = m;
    v.exp_score = s; v.exp_streak = st; v.exp_mult = mu;
    return v;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    bit early_bad;

    // rows 0..11: twelve single lane-0 hits
    for (int i = 1; i <= 12; i++) begin
      tbl.push_back(mk(0, 0, 5'b00001, 5'b00000,
                       (i <= 10) ? 50 * i : 500 + 100 * (i - 10), i, (i >= 10) ? 2 : 1));
    end
    // rows 12..28: misses, multi-lane hits, multiplier ramp/cap, pause, clear
    tbl.push_back(mk(0, 0, 5'b00000, 5'b00000,  700, 12, 2));
    tbl.push_back(mk(0, 0, 5'b00000, 5'b00001,  700,  0, 1));
    tbl.push_back(mk(0, 0, 5'b11111, 5'b00000,  950,  5, 1));
    tbl.push_back(mk(0, 0, 5'b01111, 5'b00000, 1150,  9, 1));
    tbl.push_back(mk(0, 0, 5'b10101, 5'b00001, 1150,  0, 1));
    tbl.push_back(mk(0, 0, 5'b11111, 5'b00000, 1400,  5, 1));
    tbl.push_back(mk(0, 0, 5'b11111, 5'b00000, 1650, 10, 2));
    tbl.push_back(mk(0, 0, 5'b11111, 5'b00000, 2150, 15, 2));
    tbl.push_back(mk(0, 0, 5'b11111, 5'b00000, 2650, 20, 3));
    tbl.push_back(mk(0, 0, 5'b11111, 5'b00000, 3400, 25, 3));
    tbl.push_back(mk(0, 0, 5'b11111, 5'b00000, 4150, 30, 4));
    tbl.push_back(mk(0, 0, 5'b11111, 5'b00000, 5150, 35, 4));
    tbl.push_back(mk(0, 0, 5'b00110, 5'b11000, 5150,  0, 1));
    tbl.push_back(mk(0, 0, 5'b00011, 5'b00000, 5250,  2, 1));
    tbl.push_back(mk(1, 0, 5'b11111, 5'b00000, 5250,  2, 1));
    tbl.push_back(mk(0, 1, 5'b11111, 5'b00000,    0,  0, 1));
    tbl.push_back(mk(0, 0, 5'b00001, 5'b00000,   50,  1, 1));

    reset = 1'b1; pause = 1'b0; clear = 1'b0; note_hit = '0; note_miss = '0;
`ifdef STAR_POWER_EN
    star_req = 1'b0;
`endif
    #23;
    @(negedge clk) reset = 1'b0;
    @(posedge clk); #1;
    check("rst_score",  64'(score),     64'd0);
    check("rst_streak", 64'(streak),    64'd0);
    check("rst_mult",   64'(mult),      64'd1);
    check("rst_bcd",    64'(score_bcd), 64'd0);
    check("rst_valid",  64'(bcd_valid), 64'd1);

    run_rows(0, 11);
    wait_bcd("bcd700", 28'h0000700, 60, cyc);
    run_rows(12, tbl.size() - 1);

    // clear during a conversion aborts it and shows zero immediately
    apply(0, 0, 5'b00000, 5'b00000);
    apply(0, 0, 5'b00000, 5'b00000);
    check("conv_running_valid", 64'(bcd_valid), 64'd0);
    apply(0, 1, 5'b00000, 5'b00000);
    check("clr_abort_valid", 64'(bcd_valid), 64'd1);
    check("clr_abort_bcd",   64'(score_bcd), 64'd0);
    repeat (30) begin @(posedge clk); #1; end
    check("clr_quiet_valid", 64'(bcd_valid), 64'd1);
    check("clr_quiet_bcd",   64'(score_bcd), 64'd0);

    // pause for 100 cycles freezes scoring but the converter keeps going
    repeat (3) apply(0, 0, 5'b00001, 5'b00000);
    for (int i = 0; i < 100; i++) apply(1, 0, 5'b11111, 5'b00000);
    check("pause_score",  64'(score),     64'd150);
    check("pause_streak", 64'(streak),    64'd3);
    check("pause_valid",  64'(bcd_valid), 64'd1);
    check("pause_bcd",    64'(score_bcd), 64'h150);
    apply(0, 0, 5'b00001, 5'b00000);
    check("resume_score",  64'(score),  64'd200);
    check("resume_streak", 64'(streak), 64'd4);
    wait_bcd("bcd200", 28'h0000200, 60, cyc);

    // score change mid-conversion: valid held low, result tracks final score
    apply(0, 0, 5'b00001, 5'b00000);
    early_bad = 0;
    for (int i = 0; i < 5; i++) begin
      apply(0, 0, 5'b00000, 5'b00000);
      if (bcd_valid) early_bad = 1;
    end
    apply(0, 0, 5'b00011, 5'b00000);
    check("mid_score", 64'(score), 64'd350);
    cyc = 0;
    for (int k = 0; k < 60 && !bcd_valid; k++) begin
      if (bcd_valid) early_bad = 1;
      @(posedge clk); #1;
      cyc++;
    end
    check("mid_held_low",   64'(early_bad), 64'd0);
    check("mid_valid",      64'(bcd_valid), 64'd1);
    check("mid_bcd",        64'(score_bcd), 64'h350);
    check("mid_latency_ok", 64'(cyc <= 46), 64'd1);

    // saturation near 2^21-1
    apply(0, 1, 5'b00000, 5'b00000);
    for (int i = 0; i < 6 + 2094; i++) apply(0, 0, 5'b11111, 5'b00000);
    check("sat_pre_score",  64'(score),  64'd2097000);
    check("sat_streak_max", 64'(streak), 64'd1023);
    check("sat_mult",       64'(mult),   64'd4);
    apply(0, 0, 5'b11111, 5'b00000);
    check("sat_score", 64'(score), 64'd2097151);
    apply(0, 0, 5'b00001, 5'b00000);
    check("sat_hold", 64'(score), 64'd2097151);
    wait_bcd("bcdmax", 28'h2097151, 60, cyc);

    // asynchronous reset mid-stream
    apply(0, 0, 5'b11111, 5'b00000);
    #2 reset = 1'b1;
    #1;
    check("arst_score",  64'(score),     64'd0);
    check("arst_streak", 64'(streak),    64'd0);
    check("arst_mult",   64'(mult),      64'd1);
    check("arst_bcd",    64'(score_bcd), 64'd0);
    check("arst_valid",  64'(bcd_valid), 64'd1);
    @(negedge clk) reset = 1'b0;
    @(posedge clk); #1;

`ifdef STAR_POWER_EN
    for (int i = 0; i < 6; i++) apply(0, 0, 5'b11111, 5'b00000);
    check("star_pre_score", 64'(score), 64'd3000);
    star_req = 1'b1;
    apply(0, 0, 5'b00000, 5'b00000);
    star_req = 1'b0;
    check("star_on",   64'(star_active), 64'd1);
    check("star_mult", 64'(mult),        64'd8);
    apply(0, 0, 5'b00001, 5'b00000);
    check("star_pts", 64'(score), 64'd3400);
    apply(0, 0, 5'b00000, 5'b00001);
    check("star_miss_keeps", 64'(star_active), 64'd1);
    check("star_miss_mult",  64'(mult),        64'd2);
    apply(0, 0, 5'b00001, 5'b00000);
    check("star_pts2", 64'(score), 64'd3500);
    for (int k = 0; k < 30 && star_active; k++) begin @(posedge clk); #1; end
    check("star_ends", 64'(star_active), 64'd0);
    check("star_mult_after", 64'(mult), 64'd1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
